// File: rtl/sensor_scan_sched_if.sv
// Start/done handshake and result buses shared by
// the scan scheduler and the sensor engines.
interface sensor_scan_sched_if #(
  parameter int N = 3
) ();
  logic [N-1:0] start_o;
  logic [N-1:0] done_i;
  logic [11:0]  adc_data;
  logic [7:0]   temp_bcd;

  modport master (
    output start_o,
    input  done_i,
    input  adc_data,
    input  temp_bcd
  );

  modport slave (
    input  start_o,
    output done_i,
    output adc_data,
    output temp_bcd
  );
endinterface

// File: rtl/sensor_scan_sched.sv
// Sensor scan scheduler: one engine active at a time, result held for a dwell.
// Optional WAIT timeout enabled by defining SCHED_TIMEOUT_EN.
module sensor_scan_sched #(
  parameter int NUM_SENSORS = 3,
  parameter int DWELL_CYC   = 50_000_000,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 key_pulse,
  input  logic                 auto_en,
  sensor_scan_sched_if.master  bus,
  output logic [2:0]           sen_sel,
  output logic [11:0]          value,
  output logic                 value_valid,
  output logic                 err
);

  localparam int CMAX =
    (DWELL_CYC > TIMEOUT_CYC) ? DWELL_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [2:0] TEMP_CODE = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    LATCH,
    DWELL
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]          cnt, cnt_d;
  logic [2:0]             sel_d;
  logic [2:0]             man_inc, auto_inc;
  logic [NUM_SENSORS-1:0] sel_oh, start_d;
  logic [11:0]            hold, hold_d, val_d, data_sel;
  logic                   vv_d, err_d;
  logic                   key, match, dwell_tc, tmo, cnt_wait;

  assign key = key_pulse & ~auto_en;

  assign man_inc = (sen_sel == 3'(NUM_SENSORS)) ?
                   3'd0 : sen_sel + 3'd1;

  assign auto_inc = (sen_sel == 3'(NUM_SENSORS)) ?
                    3'd1 : sen_sel + 3'd1;

  assign match = |(bus.done_i & sel_oh);

  assign dwell_tc = (state == DWELL) &&
                    (cnt == CW'(DWELL_CYC - 1));

  assign data_sel = (sen_sel == TEMP_CODE) ?
                    {4'h0, bus.temp_bcd} : bus.adc_data;

`ifdef SCHED_TIMEOUT_EN
  assign cnt_wait = (state == WAIT);
  assign tmo = (state == WAIT) && !match &&
               (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign cnt_wait = 1'b0;
  assign tmo      = 1'b0;
`endif

  // Decode the current sensor code into a one-hot lane mask.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (sen_sel == 3'(i + 1)) sel_oh[i] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next state; a manual key press overrides every slot phase.
  always_comb begin
    nxt = state;
    if (key) begin
      nxt = (man_inc == 3'd0) ? IDLE : START;
    end else begin
      unique case (state)
        IDLE:  if (auto_en || sen_sel != 3'd0) nxt = START;
        START: nxt = WAIT;
        WAIT: begin
          if (match)    nxt = LATCH;
          else if (tmo) nxt = DWELL;
        end
        LATCH: nxt = DWELL;
        DWELL: if (dwell_tc) nxt = START;
        default: nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    sel_d   = sen_sel;
    start_d = '0;
    cnt_d   = '0;
    vv_d    = value_valid;
    err_d   = err;
    hold_d  = hold;
    val_d   = value;

    if (key) begin
      sel_d = man_inc;
    end else if (state == IDLE && auto_en &&
                 sen_sel == 3'd0) begin
      sel_d = 3'd1;
    end else if (dwell_tc && auto_en) begin
      sel_d = auto_inc;
    end

    if (state == START && !key) start_d = sel_oh;

    if (!key && state == nxt &&
        (state == DWELL || cnt_wait)) begin
      cnt_d = (cnt == CW'(CMAX)) ? cnt : cnt + 1'b1;
    end

    if (key || state == IDLE)      vv_d = 1'b0;
    else if (state == LATCH)       vv_d = 1'b1;
    else if (tmo)                  vv_d = 1'b0;
    else if (dwell_tc && auto_en)  vv_d = 1'b0;

    if (state == START) err_d = 1'b0;
    else if (tmo)       err_d = 1'b1;

    if (state == WAIT && match) hold_d = data_sel;
    if (state == LATCH)         val_d  = hold;
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_sel     <= '0;
      bus.start_o <= '0;
      cnt         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      hold        <= '0;
    end else begin
      sen_sel     <= sel_d;
      bus.start_o <= start_d;
      cnt         <= cnt_d;
      value       <= val_d;
      value_valid <= vv_d;
      err         <= err_d;
      hold        <= hold_d;
    end
  end

endmodule

// File: tb/tb_sensor_scan_sched.sv
// Directed bench for sensor_scan_sched with DWELL_CYC=16, TIMEOUT_CYC=32.
// Timeout expectations follow SCHED_TIMEOUT_EN.
module tb_sensor_scan_sched;

  logic        clk;
  logic        reset_n;
  logic        key_pulse;
  logic        auto_en;
  logic [2:0]  sen_sel;
  logic [11:0] value;
  logic        value_valid;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  sensor_scan_sched_if #(.N(3)) bus ();

  sensor_scan_sched #(
    .NUM_SENSORS (3),
    .DWELL_CYC   (16),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_pulse   (key_pulse),
    .auto_en     (auto_en),
    .bus         (bus),
    .sen_sel     (sen_sel),
    .value       (value),
    .value_valid (value_valid),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    int w;
    logic [2:0]  exp_sel [4];
    logic [2:0]  oh;
    logic [11:0] exp_val;

    exp_sel[0] = 3'd1;
    exp_sel[1] = 3'd2;
    exp_sel[2] = 3'd3;
    exp_sel[3] = 3'd1;

    reset_n      = 1'b0;
    key_pulse    = 1'b0;
    auto_en      = 1'b0;
    bus.done_i   = '0;
    bus.adc_data = '0;
    bus.temp_bcd = '0;

    tick();
    tick();
    chk("rst_sel", 32'(sen_sel), 0);
    chk("rst_start", 32'(bus.start_o), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_vv", 32'(value_valid), 0);
    chk("rst_err", 32'(err), 0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_start", 32'(bus.start_o), 0);

    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
    chk("key_sel1", 32'(sen_sel), 1);
    chk("key_start_early", 32'(bus.start_o), 0);
    tick();
    chk("key_start", 32'(bus.start_o), 3'b001);
    tick();
    chk("start_1cyc", 32'(bus.start_o), 0);

    bus.done_i   = 3'b001;
    bus.adc_data = 12'hA5C;
    tick();
    bus.done_i   = '0;
    bus.adc_data = 12'h000;
    chk("latch_vv_early", 32'(value_valid), 0);
    tick();
    chk("latch_value", 32'(value), 12'hA5C);
    chk("latch_vv", 32'(value_valid), 1);
    repeat (16) tick();
    chk("dwell_no_start", 32'(bus.start_o), 0);
    tick();
    chk("dwell_start", 32'(bus.start_o), 3'b001);
    chk("dwell_sel_kept", 32'(sen_sel), 1);

    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
    chk("key_sel2", 32'(sen_sel), 2);
    chk("key_vv_clr", 32'(value_valid), 0);
    tick();
    chk("start_s2", 32'(bus.start_o), 3'b010);

    bus.done_i   = 3'b100;
    bus.temp_bcd = 8'h55;
    tick();
    bus.done_i = '0;
    tick();
    tick();
    chk("wrong_done_val", 32'(value), 12'hA5C);
    chk("wrong_done_vv", 32'(value_valid), 0);

    bus.done_i   = 3'b010;
    bus.adc_data = 12'h123;
    key_pulse    = 1'b1;
    tick();
    bus.done_i = '0;
    key_pulse  = 1'b0;
    chk("keywin_sel3", 32'(sen_sel), 3);
    tick();
    chk("start_s3", 32'(bus.start_o), 3'b100);
    tick();
    chk("keywin_value", 32'(value), 12'hA5C);
    chk("keywin_vv", 32'(value_valid), 0);

    bus.done_i   = 3'b100;
    bus.temp_bcd = 8'h27;
    tick();
    bus.done_i = '0;
    tick();
    chk("temp_value", 32'(value), 12'h027);
    chk("temp_vv", 32'(value_valid), 1);

    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
    chk("wrap_sel0", 32'(sen_sel), 0);
    chk("wrap_vv", 32'(value_valid), 0);
    tick();
    tick();
    chk("idle_no_start", 32'(bus.start_o), 0);

    auto_en = 1'b1;
    tick();
    chk("auto_sel1", 32'(sen_sel), 1);

    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (bus.start_o == 3'b000 && w < 40) begin
        tick();
        w++;
      end
      chk("auto_wait", 32'(w < 40), 1);
      oh = 3'b001 << (exp_sel[k] - 3'd1);
      chk("auto_sel", 32'(sen_sel), 32'(exp_sel[k]));
      chk("auto_start", 32'(bus.start_o), 32'(oh));
      repeat (9) tick();
      bus.done_i   = oh;
      bus.adc_data = 12'h100 + 12'(k * 17);
      bus.temp_bcd = 8'h27;
      exp_val = (exp_sel[k] == 3'd3) ?
                12'h027 : 12'h100 + 12'(k * 17);
      tick();
      bus.done_i = '0;
      tick();
      chk("auto_value", 32'(value), 32'(exp_val));
      chk("auto_vv", 32'(value_valid), 1);
    end

    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
    chk("auto_key_ign", 32'(sen_sel), 1);
    chk("auto_key_vv", 32'(value_valid), 1);

    auto_en = 1'b0;
    w = 0;
    while (bus.start_o == 3'b000 && w < 40) begin
      tick();
      w++;
    end
    chk("man_wait", 32'(w < 40), 1);
    chk("man_sel_kept", 32'(sen_sel), 1);

`ifdef SCHED_TIMEOUT_EN
    repeat (31) tick();
    chk("tmo_err_early", 32'(err), 0);
    tick();
    chk("tmo_err", 32'(err), 1);
    chk("tmo_vv", 32'(value_valid), 0);
    chk("tmo_value", 32'(value), 12'h133);
    w = 0;
    while (bus.start_o == 3'b000 && w < 40) begin
      tick();
      w++;
    end
    chk("tmo_wait", 32'(w < 40), 1);
    chk("tmo_err_clr", 32'(err), 0);
`else
    repeat (40) tick();
    chk("notmo_err", 32'(err), 0);
    chk("notmo_vv", 32'(value_valid), 1);
    chk("notmo_start", 32'(bus.start_o), 0);
`endif

    reset_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sen_sel), 0);
    chk("arst_value", 32'(value), 0);
    chk("arst_vv", 32'(value_valid), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_start", 32'(bus.start_o), 0);
    #2;
    reset_n = 1'b1;
    tick();
    bus.done_i   = 3'b001;
    bus.adc_data = 12'hFFF;
    tick();
    bus.done_i = '0;
    tick();
    tick();
    chk("stale_vv", 32'(value_valid), 0);
    chk("stale_value", 32'(value), 0);
    chk("stale_sel", 32'(sen_sel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
